// File: rtl/dmem_pkg.sv
// Shared widths, access-mode encodings and grant-select type for the data-memory port arbiter.
package dmem_pkg;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int MODE_W = 2;

   localparam logic [1:0] MODE_BYTE = 2'd0;
   localparam logic [1:0] MODE_HALF = 2'd1;
   localparam logic [1:0] MODE_WORD = 2'd2;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_A    = 2'd1,
      SEL_B    = 2'd2
   } gnt_sel_e;
endpackage

// File: rtl/starve_ctr.sv
// Tracks consecutive denied cycles of port B and raises force_b once MAX_WAIT is reached,
// holding it until the cycle after B is finally granted.
module starve_ctr
   import dmem_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_b_req,
   input  logic i_b_gnt,
   output logic o_force_b
);
   localparam int CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] r_b_wait;
   logic [CW-1:0] w_b_wait_next;
   logic          r_force_b;
   logic          w_force_b_next;

   always_comb begin
      w_b_wait_next  = '0;
      w_force_b_next = r_force_b;
      if (i_b_gnt) begin
         w_force_b_next = 1'b0;
      end else if (i_b_req) begin
         // Saturate so the count stays within 0..MAX_WAIT.
         if (r_b_wait < CW'(MAX_WAIT)) w_b_wait_next = r_b_wait + CW'(1);
         else                          w_b_wait_next = r_b_wait;
         if (w_b_wait_next == CW'(MAX_WAIT)) w_force_b_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_b_wait  <= '0;
         r_force_b <= 1'b0;
      end else begin
         r_b_wait  <= w_b_wait_next;
         r_force_b <= w_force_b_next;
      end
   end

   assign o_force_b = r_force_b;
endmodule

// File: rtl/dmem_port_arb.sv
// Fixed-priority (A over B) arbiter for the shared data-memory port with bounded B starvation,
// registered read return per port and a saturating contention counter.
module dmem_port_arb #(
   parameter int ADDR_W   = dmem_pkg::ADDR_W,
   parameter int DATA_W   = dmem_pkg::DATA_W,
   parameter int MODE_W   = dmem_pkg::MODE_W,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [MODE_W-1:0] a_mode,
   input  logic [DATA_W-1:0] a_wdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [MODE_W-1:0] b_mode,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              a_gnt,
   output logic              b_gnt,
   output logic              a_rvalid,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   output logic [DATA_W-1:0] b_rdata,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_waddr,
   output logic [ADDR_W-1:0] m_raddr,
   output logic [MODE_W-1:0] m_mode,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   output logic [15:0]       conflict_cnt
);
   import dmem_pkg::*;

   gnt_sel_e          w_sel;
   logic              w_force_b;
   logic [1:0]        w_rd_gnt;
   logic              r_rvalid [2];
   logic [DATA_W-1:0] r_rdata  [2];
   logic [15:0]       r_conflict_cnt;

   starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve_ctr (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_b_req   (b_req),
      .i_b_gnt   (b_gnt),
      .o_force_b (w_force_b)
   );

   always_comb begin
      w_sel = SEL_NONE;
      if (rst_n) begin
         if (w_force_b && b_req) w_sel = SEL_B;
         else if (a_req)         w_sel = SEL_A;
         else if (b_req)         w_sel = SEL_B;
      end
   end

   assign a_gnt = (w_sel == SEL_A);
   assign b_gnt = (w_sel == SEL_B);

   // One address bus feeds both the read and the write side of the memory.
   always_comb begin
      m_we    = 1'b0;
      m_waddr = '0;
      m_raddr = '0;
      m_mode  = '0;
      m_wdata = '0;
      case (w_sel)
         SEL_A: begin
            m_we    = a_we;
            m_waddr = a_addr;
            m_raddr = a_addr;
            m_mode  = a_mode;
            m_wdata = a_wdata;
         end
         SEL_B: begin
            m_we    = b_we;
            m_waddr = b_addr;
            m_raddr = b_addr;
            m_mode  = b_mode;
            m_wdata = b_wdata;
         end
         default: ;
      endcase
   end

   assign w_rd_gnt = {b_gnt & ~b_we, a_gnt & ~a_we};

   for (genvar gi = 0; gi < 2; gi++) begin : g_ret
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_rvalid[gi] <= 1'b0;
            r_rdata[gi]  <= '0;
         end else begin
            r_rvalid[gi] <= w_rd_gnt[gi];
            if (w_rd_gnt[gi]) r_rdata[gi] <= m_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)                                            r_conflict_cnt <= '0;
      else if (a_req && b_req && (r_conflict_cnt != 16'hFFFF)) r_conflict_cnt <= r_conflict_cnt + 16'd1;
   end

   // Outputs read as zero while reset is held, so a read granted just before reset never shows.
   assign a_rvalid     = r_rvalid[0] & rst_n;
   assign b_rvalid     = r_rvalid[1] & rst_n;
   assign a_rdata      = rst_n ? r_rdata[0] : '0;
   assign b_rdata      = rst_n ? r_rdata[1] : '0;
   assign conflict_cnt = rst_n ? r_conflict_cnt : '0;
endmodule

// File: tb/tb_dmem_port_arb.sv
// Randomized + directed bench for dmem_port_arb: a reference model predicts grants and memory
// drive each cycle, and a monitor pops queued read expectations whenever rvalid appears.
module tb_dmem_port_arb;
   import dmem_pkg::*;

   localparam int MAX_WAIT = 4;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [7:0]  addr;
      logic [1:0]  mode;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   logic        clk, rst_n;
   logic        a_req, a_we, b_req, b_we;
   logic [7:0]  a_addr, b_addr;
   logic [1:0]  a_mode, b_mode;
   logic [31:0] a_wdata, b_wdata;
   logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
   logic [31:0] a_rdata, b_rdata;
   logic        m_we;
   logic [7:0]  m_waddr, m_raddr;
   logic [1:0]  m_mode;
   logic [31:0] m_wdata, m_rdata;
   logic [15:0] conflict_cnt;

   dmem_port_arb #(.ADDR_W(8), .DATA_W(32), .MODE_W(2), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_mode(a_mode), .a_wdata(a_wdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_mode(b_mode), .b_wdata(b_wdata),
      .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
      .a_rdata(a_rdata), .b_rdata(b_rdata),
      .m_we(m_we), .m_waddr(m_waddr), .m_raddr(m_raddr), .m_mode(m_mode),
      .m_wdata(m_wdata), .m_rdata(m_rdata), .conflict_cnt(conflict_cnt)
   );

   int          n_err, n_chk, cyc;
   exp_t        exp_q [2][$];
   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];
   logic        mem_load, verbose;
   int          ref_wait, ref_cc;
   logic        ref_force, last_ga, last_gb;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(input logic [7:0] a);
      return {a, a, a, a} ^ 32'h44332211;
   endfunction

   // Behavioural d_mem: combinational read, write at the end of the grant cycle.
   assign m_rdata = mem[m_raddr];
   always @(posedge clk) begin
      if (mem_load) for (int i = 0; i < 256; i++) mem[i] <= init_word(8'(i));
      else if (m_we) mem[m_waddr] <= m_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic req_t mk(input logic we, input logic [7:0] addr, input logic [1:0] mode,
                               input logic [31:0] wdata);
      req_t r;
      r.req = 1'b1; r.we = we; r.addr = addr; r.mode = mode; r.wdata = wdata;
      return r;
   endfunction

   function automatic req_t rnd_req();
      req_t r;
      r.req   = ($urandom_range(0, 2) != 0);
      r.we    = 1'($urandom_range(0, 1));
      r.addr  = 8'($urandom_range(0, 15));
      r.mode  = 2'($urandom_range(0, 2));
      r.wdata = $urandom;
      return r;
   endfunction

   // One clock cycle: drive, check combinational outputs against the model, advance the model.
   task automatic step(input logic rst, input req_t ra, input req_t rb);
      logic ga, gb;
      req_t g;
      exp_t e;
      @(negedge clk);
      if (!rst) begin
         exp_q[0].delete();
         exp_q[1].delete();
      end
      rst_n = rst;
      a_req = ra.req; a_we = ra.we; a_addr = ra.addr; a_mode = ra.mode; a_wdata = ra.wdata;
      b_req = rb.req; b_we = rb.we; b_addr = rb.addr; b_mode = rb.mode; b_wdata = rb.wdata;
      #1;
      ga = 1'b0;
      gb = 1'b0;
      if (rst) begin
         if (ref_force && rb.req) gb = 1'b1;
         else if (ra.req)         ga = 1'b1;
         else if (rb.req)         gb = 1'b1;
      end
      g = ga ? ra : (gb ? rb : '0);
      chk("a_gnt", 32'(a_gnt), 32'(ga));
      chk("b_gnt", 32'(b_gnt), 32'(gb));
      chk("m_we", 32'(m_we), 32'(g.we));
      chk("m_waddr", 32'(m_waddr), 32'(g.addr));
      chk("m_raddr", 32'(m_raddr), 32'(g.addr));
      chk("m_mode", 32'(m_mode), 32'(g.mode));
      chk("m_wdata", m_wdata, g.wdata);
      chk("conflict_cnt", 32'(conflict_cnt), rst ? 32'(ref_cc) : 32'd0);
      if (ga || gb) begin
         if (verbose)
            $display("[%0d] port %s %s addr=%h mode=%0d data=%h", cyc, ga ? "A" : "B",
                     g.we ? "WR" : "RD", g.addr, g.mode, g.we ? g.wdata : ref_mem[g.addr]);
         if (g.we) ref_mem[g.addr] = g.wdata;
         else begin
            e.due  = cyc + 1;
            e.data = ref_mem[g.addr];
            exp_q[gb ? 1 : 0].push_back(e);
         end
      end
      if (!rst) begin
         ref_wait  = 0;
         ref_force = 1'b0;
         ref_cc    = 0;
      end else begin
         if (ra.req && rb.req && ref_cc < 65535) ref_cc++;
         if (gb) begin
            ref_wait  = 0;
            ref_force = 1'b0;
         end else if (!rb.req) begin
            ref_wait = 0;
         end else begin
            ref_wait++;
            if (ref_wait >= MAX_WAIT) ref_force = 1'b1;
         end
      end
      last_ga = ga;
      last_gb = gb;
   endtask

   // Read-return monitor, decoupled from stimulus.
   initial begin
      exp_t e;
      logic rv;
      logic [31:0] rd;
      forever begin
         @(negedge clk);
         #2;
         for (int p = 0; p < 2; p++) begin
            rv = (p == 0) ? a_rvalid : b_rvalid;
            rd = (p == 0) ? a_rdata  : b_rdata;
            if (rv) begin
               if (exp_q[p].size() == 0) begin
                  chk(p == 0 ? "a_rvalid_unexpected" : "b_rvalid_unexpected", 32'(rv), 32'd0);
               end else begin
                  e = exp_q[p].pop_front();
                  chk(p == 0 ? "a_rvalid_cycle" : "b_rvalid_cycle", 32'(cyc), 32'(e.due));
                  chk(p == 0 ? "a_rdata" : "b_rdata", rd, e.data);
               end
            end else if (exp_q[p].size() != 0 && exp_q[p][0].due <= cyc) begin
               e = exp_q[p].pop_front();
               chk(p == 0 ? "a_rvalid_missing" : "b_rvalid_missing", 32'(rv), 32'd1);
            end
         end
      end
   end

   initial begin
      req_t idle, ra, rb, rdA, sat_a, sat_b;
      n_err = 0; n_chk = 0;
      ref_wait = 0; ref_force = 1'b0; ref_cc = 0;
      last_ga = 1'b0; last_gb = 1'b0;
      mem_load = 1'b1; verbose = 1'b1;
      rst_n = 1'b0;
      a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_mode = '0; a_wdata = '0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_mode = '0; b_wdata = '0;
      idle = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));

      step(1'b0, idle, idle);
      step(1'b0, idle, idle);
      mem_load = 1'b0;
      step(1'b1, idle, idle);
      chk("reset_a_rvalid", 32'(a_rvalid), 32'd0);
      chk("reset_b_rvalid", 32'(b_rvalid), 32'd0);
      chk("reset_a_rdata", a_rdata, 32'd0);
      chk("reset_conflict_cnt", 32'(conflict_cnt), 32'd0);

      // Starvation: both held, B forced in cycle 4.
      for (int i = 0; i < 6; i++) begin
         step(1'b1, mk(1'b1, 8'h10, MODE_WORD, 32'(32'h1000 + i)), mk(1'b1, 8'h20, MODE_WORD, 32'h2222));
         chk("starve_a_gnt", 32'(a_gnt), 32'(i != 4));
         chk("starve_b_gnt", 32'(b_gnt), 32'(i == 4));
      end
      step(1'b1, idle, idle);
      chk("conflict_cnt_6", 32'(conflict_cnt), 32'd6);

      // Uncontended A write then read back.
      step(1'b1, mk(1'b1, 8'h40, MODE_WORD, 32'hDEADBEEF), idle);
      chk("a_wr_gnt", 32'(a_gnt), 32'd1);
      step(1'b1, mk(1'b0, 8'h40, MODE_WORD, 32'd0), idle);
      chk("a_rd_gnt", 32'(a_gnt), 32'd1);
      step(1'b1, idle, idle);
      chk("a_rd_rvalid", 32'(a_rvalid), 32'd1);
      chk("a_rd_data", a_rdata, 32'hDEADBEEF);
      chk("a_rd_b_rvalid", 32'(b_rvalid), 32'd0);

      // Uncontended B read of preloaded word.
      step(1'b1, idle, mk(1'b0, 8'h00, MODE_WORD, 32'd0));
      chk("b_rd_gnt", 32'(b_gnt), 32'd1);
      step(1'b1, idle, idle);
      chk("b_rd_rvalid", 32'(b_rvalid), 32'd1);
      chk("b_rd_data", b_rdata, 32'h44332211);

      // Mode passthrough, single-cycle write strobe.
      step(1'b1, idle, mk(1'b1, 8'h83, MODE_BYTE, 32'h000000AA));
      chk("byte_m_mode", 32'(m_mode), 32'd0);
      chk("byte_m_waddr", 32'(m_waddr), 32'h83);
      chk("byte_m_we", 32'(m_we), 32'd1);
      step(1'b1, idle, idle);
      chk("byte_m_we_off", 32'(m_we), 32'd0);

      // Reset the cycle after an A read grant.
      rdA = mk(1'b0, 8'h40, MODE_WORD, 32'd0);
      step(1'b1, rdA, idle);
      chk("rst_rd_gnt", 32'(a_gnt), 32'd1);
      step(1'b0, rdA, mk(1'b0, 8'h00, MODE_WORD, 32'd0));
      chk("rst_no_rvalid", 32'(a_rvalid), 32'd0);
      chk("rst_a_rdata", a_rdata, 32'd0);
      chk("rst_a_gnt", 32'(a_gnt), 32'd0);
      chk("rst_b_gnt", 32'(b_gnt), 32'd0);
      chk("rst_m_we", 32'(m_we), 32'd0);
      step(1'b0, rdA, mk(1'b0, 8'h00, MODE_WORD, 32'd0));
      chk("rst_hold_gnt", 32'({a_gnt, b_gnt}), 32'd0);
      step(1'b1, idle, idle);

      // Randomized traffic obeying the hold-until-grant rule.
      ra = rnd_req();
      rb = rnd_req();
      for (int i = 0; i < 400; i++) begin
         step(1'b1, ra, rb);
         if (last_ga || !ra.req) ra = rnd_req();
         else if ($urandom_range(0, 7) == 0) ra.req = 1'b0;
         if (last_gb || !rb.req) rb = rnd_req();
         else if ($urandom_range(0, 7) == 0) rb.req = 1'b0;
      end

      // Saturation of the contention counter.
      verbose = 1'b0;
      step(1'b0, idle, idle);
      sat_a = mk(1'b1, 8'h30, MODE_WORD, 32'h5A5A5A5A);
      sat_b = mk(1'b1, 8'h31, MODE_HALF, 32'hA5A5A5A5);
      for (int i = 0; i < 70000; i++) step(1'b1, sat_a, sat_b);
      chk("conflict_sat", 32'(conflict_cnt), 32'h0000FFFF);
      step(1'b1, sat_a, sat_b);
      chk("conflict_no_wrap", 32'(conflict_cnt), 32'h0000FFFF);

      step(1'b1, idle, idle);
      step(1'b1, idle, idle);
      step(1'b1, idle, idle);
      chk("pending_reads", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/dmem_port_arb.md
# dmem_port_arb

Two-requester arbiter that shares the single data-memory port (8-bit byte address, 32-bit data, 2-bit access mode) between the CPU load/store unit (port A) and a secondary master such as a debug loader or signature dumper (port B).
- Port A has fixed priority; a starvation counter guarantees port B service within a bounded wait.
- Read data is returned registered, one cycle after grant.
- The block sits between the core/debug masters and `d_mem`, and counts contention cycles for performance reporting.

## Interface
Parameters:
- ADDR_W, 8: byte address width.
- DATA_W, 32: data width.
- MODE_W, 2: access mode width (byte/half/word), passed through unchanged.
- MAX_WAIT, 4: maximum consecutive cycles port B may be denied while requesting (≥1).

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, synchronous, active-low.
- a_req / b_req, in, 1: request; held stable with its attributes until the matching gnt.
- a_we / b_we, in, 1: 1 = write, 0 = read.
- a_addr / b_addr, in, ADDR_W: byte address.
- a_mode / b_mode, in, MODE_W: access mode.
- a_wdata / b_wdata, in, DATA_W: write data.
- a_gnt / b_gnt, out, 1: transaction issued this cycle.
- a_rvalid / b_rvalid, out, 1: read data valid, one cycle after a read grant.
- a_rdata / b_rdata, out, DATA_W: registered read data.
- m_we, out, 1: memory write enable.
- m_waddr, m_raddr, out, ADDR_W: memory write and read addresses.
- m_mode, out, MODE_W: memory access mode.
- m_wdata, out, DATA_W: memory write data.
- m_rdata, in, DATA_W: memory read data (combinational from m_raddr).
- conflict_cnt, out, 16: saturating count of cycles with both requests high.

## Operation
**State**
- Registered state holds `b_wait` (0..MAX_WAIT), `force_b` (1 bit), and the read-return registers.

**Grant rule** (combinational from current requests and registered state, one grant per cycle)
- `force_b = 1` and b_req: grant B.
- Otherwise a_req: grant A.
- Otherwise b_req: grant B.
- Otherwise no grant.

**Starvation counter**
- b_req & !b_gnt: `b_wait += 1`.
- b_gnt or !b_req: `b_wait` clears.
- When `b_wait` reaches MAX_WAIT, set `force_b`.
- `force_b` clears on the cycle after b_gnt.

**Memory drive**
- Granted port's addr drives both m_waddr and m_raddr.
- m_mode and m_wdata come from the granted port.
- m_we = granted port's we.
- With no grant: m_we = 0, all other m_* = 0.

**Read return**
- A read grant registers m_rdata into that port's rdata and pulses its rvalid for exactly one cycle.
- rdata holds its last value otherwise.
- Writes produce no rvalid.

**Conflict counter**
- conflict_cnt increments when a_req & b_req, and saturates at 0xFFFF.

**Rules**
- Requesters must not change attributes while req is high and gnt is low.
- A requester may drop req without being granted; no side effect.

## Timing
- Grant latency: 0 cycles when uncontended (gnt in the same cycle as req).
- Write commits at the clock edge ending the grant cycle.
- Read data: rvalid/rdata at cycle N+1 for a grant at cycle N.
- Back-to-back grants to the same port are allowed every cycle.
- Worst-case B wait: MAX_WAIT denied cycles, then granted on the next cycle in which b_req is high.
- A is stalled exactly one cycle per forced B grant.
- **Reset** (rst_n = 0 at a clock edge):
  - `b_wait = 0`, `force_b = 0`.
  - rvalid = 0, rdata = 0, conflict_cnt = 0.
  - While rst_n = 0, both gnt = 0 and m_we = 0 regardless of requests.
- **Reset mid-transaction:** a read granted in the cycle before reset returns no rvalid.
- **Simultaneous requests**, force_b = 0: A wins and B's wait increments.
- **Simultaneous requests**, force_b = 1: B wins; A's request is held, A gnt = 0.

## Structure
- Shared package `dmem_pkg` holds:
  - ADDR_W, DATA_W, MODE_W defaults.
  - Mode encodings: MODE_BYTE = 0, MODE_HALF = 1, MODE_WORD = 2.
- Sub-module `starve_ctr`: `b_wait` plus `force_b` logic, parameterized by MAX_WAIT.
- The grant mux and read-return registers stay in the top module.

## Test plan
- **Uncontended A:** A write 0xDEADBEEF @0x40 mode WORD, then A read @0x40.
  - a_gnt same cycle both times.
  - a_rvalid one cycle later with a_rdata = 0xDEADBEEF.
  - b_rvalid stays 0.
- **Uncontended B:** B read @0x00 with memory preloaded 0x44332211.
  - b_gnt immediately; b_rvalid next cycle with 0x44332211.
- **Starvation, MAX_WAIT = 4:** a_req and b_req held high continuously.
  - A granted in cycles 0–3, B granted in cycle 4 (a_gnt = 0), A resumes in cycle 5.
  - conflict_cnt = 6 after 6 cycles.
- **Reset mid-read:** assert rst_n = 0 the cycle after an A read grant.
  - No a_rvalid; all outputs 0.
  - gnt stays 0 while reset is held with requests high.
- **Mode passthrough:** B write mode BYTE of 0x000000AA @0x83.
  - m_mode = 0, m_waddr = 0x83, m_we = 1 for exactly one cycle.
- **Saturation:** hold both requests for 70000 cycles → conflict_cnt = 0xFFFF and does not wrap.
